// File: rtl/adc_ctrl_pkg.sv
// Shared types for the AD9228 capture sequencer: FSM state encoding and
// trigger-source selection codes.
package adc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FIFO_RST = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_ARMED    = 3'd3,
      ST_CAPTURE  = 3'd4,
      ST_DONE     = 3'd5
   } capture_state_e;

   localparam logic [1:0] TRIG_SW  = 2'd0;
   localparam logic [1:0] TRIG_EXT = 2'd1;
   localparam logic [1:0] TRIG_ANY = 2'd2;
   localparam logic [1:0] TRIG_IMM = 2'd3;

   // Immediate mode qualifies on every cycle, so ARMED is left on its first cycle.
   function automatic logic trig_qualify(input logic [1:0] sel,
                                         input logic       sw,
                                         input logic       ext);
      logic ok;
      case (sel)
         TRIG_SW:  ok = sw;
         TRIG_EXT: ok = ext;
         TRIG_ANY: ok = sw | ext;
         default:  ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Brings the asynchronous external trigger into clk and emits a registered
// one-cycle pulse on its rising edge (three cycles from input to pulse).
module trig_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
         pulse  <= sync & ~sync_d;
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for a bank of AD9228 channel readers: FIFO reset, settle,
// trigger wait, then a counted burst of the shared FIFO write enable.
module adc_capture_ctrl
   import adc_ctrl_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int CNT_WIDTH       = 16,
   parameter int FIFO_RST_CYCLES = 8,
   parameter int SETTLE_CYCLES   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 sw_trig,
   input  logic                 ext_trig,
   input  logic [1:0]           trig_sel,
   input  logic [CNT_WIDTH-1:0] capture_len,
   input  logic [NUM_CH-1:0]    fifo_full,
   output logic                 read_en,
   output logic                 fifo_rstn,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic [2:0]           state_o,
   output logic [CNT_WIDTH-1:0] sample_count
);

   localparam int TMR_MAX = (FIFO_RST_CYCLES > SETTLE_CYCLES) ? FIFO_RST_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0]     RST_LAST    = TMR_W'(FIFO_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0]     SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0]     TMR_SAT     = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_SAT     = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   capture_state_e       state;
   capture_state_e       next_state;
   logic [TMR_W-1:0]     tmr;
   logic [CNT_WIDTH-1:0] len_q;
   logic                 ext_pulse;
   logic                 trig_ok;
   logic                 any_full;
   logic                 last_sample;
   logic                 arm_take;
   logic                 read_en_d;
   logic                 fifo_rstn_d;
   logic                 busy_d;
   logic                 done_d;

   trig_sync_edge u_trig_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (ext_trig),
      .pulse    (ext_pulse)
   );

   assign trig_ok     = trig_qualify(trig_sel, sw_trig, ext_pulse);
   assign any_full    = |fifo_full;
   // Stop after this write so exactly len_q cycles carry read_en.
   assign last_sample = (sample_count == (len_q - CNT_ONE));
   assign arm_take    = ((state == ST_IDLE) || (state == ST_DONE)) && arm && !abort;
   assign state_o     = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (arm) next_state = ST_FIFO_RST;
            end
            ST_FIFO_RST: begin
               if (tmr == RST_LAST) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (tmr == SETTLE_LAST) next_state = ST_ARMED;
            end
            ST_ARMED: begin
               if (trig_ok) next_state = (len_q == '0) ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (any_full || last_sample) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from next_state and registered alongside it.
   always_comb begin
      read_en_d   = (next_state == ST_CAPTURE);
      fifo_rstn_d = (next_state != ST_FIFO_RST);
      busy_d      = (next_state != ST_IDLE) && (next_state != ST_DONE);
      done_d      = (next_state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_en   <= 1'b0;
         fifo_rstn <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         read_en   <= read_en_d;
         fifo_rstn <= fifo_rstn_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr <= '0;
      end else if (next_state != state) begin
         tmr <= '0;
      end else if (tmr != TMR_SAT) begin
         tmr <= tmr + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q        <= '0;
         sample_count <= '0;
         overflow     <= 1'b0;
      end else if (arm_take) begin
         len_q        <= capture_len;
         sample_count <= '0;
         overflow     <= 1'b0;
      end else begin
         if (read_en && (sample_count != CNT_SAT)) sample_count <= sample_count + CNT_ONE;
         if (read_en && any_full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a table of capture scenarios plus
// hand sequences for trigger paths, arm/abort interactions and async reset.
module tb_adc_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        arm;
   logic        abort;
   logic        sw_trig;
   logic        ext_trig;
   logic [1:0]  trig_sel;
   logic [15:0] capture_len;
   logic [3:0]  fifo_full;
   logic        read_en;
   logic        fifo_rstn;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [2:0]  state_o;
   logic [15:0] sample_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] sel;
      int         len;
      int         delay;
      int         full_at;
      int         abort_at;
      int         exp_writes;
      int         exp_cnt;
      logic       exp_ovf;
      logic       exp_done;
      logic [2:0] exp_state;
   } vec_t;

   vec_t vecs[6];

   adc_capture_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .arm          (arm),
      .abort        (abort),
      .sw_trig      (sw_trig),
      .ext_trig     (ext_trig),
      .trig_sel     (trig_sel),
      .capture_len  (capture_len),
      .fifo_full    (fifo_full),
      .read_en      (read_en),
      .fifo_rstn    (fifo_rstn),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .state_o      (state_o),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input string name, input logic [2:0] s, input int budget);
      int g;
      g = 0;
      while ((state_o != s) && (g < budget)) begin
         step();
         g++;
      end
      check(name, {29'd0, state_o}, {29'd0, s});
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic pulse_sw();
      sw_trig = 1'b1;
      step();
      sw_trig = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int rst_low;
      int writes;
      int g;
      trig_sel    = v.sel;
      capture_len = 16'(v.len);
      fifo_full   = '0;
      pulse_arm();
      rst_low = 0;
      g = 0;
      while ((state_o != 3'd3) && (g < 200)) begin
         if (!fifo_rstn) rst_low++;
         step();
         g++;
      end
      check($sformatf("v%0d_reach_armed", idx), state_o, 3'd3);
      check($sformatf("v%0d_fifo_rst_cycles", idx), rst_low, 8);
      if (v.sel != 2'd3) begin
         repeat (v.delay) step();
         pulse_sw();
         check($sformatf("v%0d_read_en_after_trig", idx), read_en, v.len != 0);
      end
      writes = 0;
      g = 0;
      while ((state_o != 3'd5) && (state_o != 3'd0) && (g < 400)) begin
         if (read_en) begin
            writes++;
            if (writes == v.full_at) fifo_full = 4'b0100;
            if (writes == v.abort_at) abort = 1'b1;
         end
         step();
         g++;
      end
      fifo_full = '0;
      abort     = 1'b0;
      check($sformatf("v%0d_writes", idx), writes, v.exp_writes);
      check($sformatf("v%0d_sample_count", idx), sample_count, v.exp_cnt);
      check($sformatf("v%0d_overflow", idx), overflow, v.exp_ovf);
      check($sformatf("v%0d_done", idx), done, v.exp_done);
      check($sformatf("v%0d_state", idx), state_o, v.exp_state);
      check($sformatf("v%0d_read_en_low", idx), read_en, 0);
      check($sformatf("v%0d_busy", idx), busy, 0);
   endtask

   initial begin
      int n;
      int writes;
      int g;

      vecs[0] = '{2'd0, 100, 10, 0, 0, 100, 100, 1'b0, 1'b1, 3'd5};
      vecs[1] = '{2'd0, 50, 3, 20, 0, 20, 20, 1'b1, 1'b1, 3'd5};
      vecs[2] = '{2'd0, 100, 2, 0, 30, 30, 30, 1'b0, 1'b0, 3'd0};
      vecs[3] = '{2'd3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 3'd5};
      vecs[4] = '{2'd3, 1, 0, 0, 0, 1, 1, 1'b0, 1'b1, 3'd5};
      vecs[5] = '{2'd2, 7, 0, 0, 0, 7, 7, 1'b0, 1'b1, 3'd5};

      rst = 1'b1; arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0;
      trig_sel = 2'd0; capture_len = '0; fifo_full = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_read_en", read_en, 0);
      check("reset_fifo_rstn", fifo_rstn, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overflow", overflow, 0);
      check("reset_state", state_o, 0);
      check("reset_count", sample_count, 0);
      step();

      for (int i = 0; i < 6; i++) begin
         run_vec(i, vecs[i]);
         step();
      end

      // External trigger: sw_trig must be ignored, then ext edge to read_en in 4 edges.
      trig_sel = 2'd1; capture_len = 16'd100;
      pulse_arm();
      wait_state("ext_reach_armed", 3'd3, 100);
      pulse_sw();
      repeat (3) step();
      check("ext_sw_ignored_state", state_o, 3'd3);
      check("ext_sw_ignored_read_en", read_en, 0);
      #2;
      ext_trig = 1'b1;
      n = 0;
      while ((n < 20) && !read_en) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ext_latency_edges", n, 4);
      writes = 0;
      g = 0;
      while (read_en && (g < 300)) begin
         writes++;
         step();
         g++;
      end
      ext_trig = 1'b0;
      check("ext_writes", writes, 100);
      check("ext_count", sample_count, 100);
      check("ext_done", done, 1);

      // Trigger during SETTLE is dropped.
      trig_sel = 2'd0; capture_len = 16'd5;
      pulse_arm();
      wait_state("settle_reach", 3'd2, 50);
      repeat (3) step();
      pulse_sw();
      wait_state("settle_then_armed", 3'd3, 100);
      repeat (5) step();
      check("settle_trig_dropped_state", state_o, 3'd3);
      check("settle_trig_dropped_read_en", read_en, 0);
      pulse_sw();
      wait_state("settle_later_done", 3'd5, 50);
      check("settle_later_count", sample_count, 5);

      // Arm together with a trigger in ARMED: trigger wins, FIFOs not reset.
      capture_len = 16'd3;
      pulse_arm();
      wait_state("armtrig_reach_armed", 3'd3, 100);
      arm = 1'b1;
      sw_trig = 1'b1;
      step();
      arm = 1'b0;
      sw_trig = 1'b0;
      check("armtrig_state", state_o, 3'd4);
      check("armtrig_read_en", read_en, 1);
      check("armtrig_fifo_rstn", fifo_rstn, 1);
      wait_state("armtrig_done", 3'd5, 50);
      check("armtrig_count", sample_count, 3);

      // Arm during CAPTURE is ignored.
      trig_sel = 2'd3; capture_len = 16'd40;
      pulse_arm();
      wait_state("armcap_reach_capture", 3'd4, 100);
      repeat (10) step();
      capture_len = 16'd7;
      pulse_arm();
      check("armcap_still_capture", state_o, 3'd4);
      wait_state("armcap_done", 3'd5, 100);
      check("armcap_count", sample_count, 40);

      // Abort from DONE holds the count; abort beats a simultaneous arm.
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_done_state", state_o, 3'd0);
      check("abort_done_done", done, 0);
      check("abort_done_count", sample_count, 40);
      arm = 1'b1;
      abort = 1'b1;
      step();
      arm = 1'b0;
      abort = 1'b0;
      check("abort_beats_arm_state", state_o, 3'd0);
      check("abort_beats_arm_count", sample_count, 40);

      // Async reset pulse mid-capture, away from any clock edge.
      capture_len = 16'd100;
      pulse_arm();
      wait_state("areset_reach_capture", 3'd4, 100);
      repeat (5) step();
      #2;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      check("areset_read_en", read_en, 0);
      check("areset_fifo_rstn", fifo_rstn, 1);
      check("areset_busy", busy, 0);
      check("areset_state", state_o, 0);
      check("areset_count", sample_count, 0);
      check("areset_done", done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences one capture on a bank of AD9228 single-channel readers that share a clock and write enable. On arm it resets the channel FIFOs and waits for them to settle. It then waits for a software or external trigger and asserts the common FIFO write enable for a programmed number of sample clocks. It reports done, overflow and status to the register/AXI layer.

Parameters:
NUM_CH, 4, number of channel FIFOs supervised (width of fifo_full input)
CNT_WIDTH, 16, width of capture length and sample counter
FIFO_RST_CYCLES, 8, clk cycles fifo_rstn is held low after arm
SETTLE_CYCLES, 32, clk cycles waited after FIFO reset release before accepting a trigger

Ports:
clk  input  1  sample clock, same clock as the FIFO write side
rst  input  1  asynchronous active-high reset
arm  input  1  single-cycle pulse: start a capture sequence
abort  input  1  single-cycle pulse: cancel the sequence from any state
sw_trig  input  1  single-cycle software trigger
ext_trig  input  1  asynchronous external trigger level, rising edge active
trig_sel  input  2  0=sw only, 1=ext only, 2=either, 3=immediate (trigger on entering ARMED)
capture_len  input  CNT_WIDTH  samples to write, sampled on arm
fifo_full  input  NUM_CH  per-channel FIFO full flags
read_en  output  1  common FIFO write enable to all channel readers
fifo_rstn  output  1  active-low FIFO reset to all channel readers
busy  output  1  high in every state except IDLE and DONE
done  output  1  high in DONE
overflow  output  1  sticky: a FIFO was full while read_en was high
state_o  output  3  current state encoding, for status register
sample_count  output  CNT_WIDTH  samples written in the current or last capture

Behaviour:
- All outputs are registered. Reset values: read_en=0, fifo_rstn=1, busy=0, done=0, overflow=0, state_o=IDLE, sample_count=0.
- ext_trig passes through a 2-FF synchronizer and then a rising-edge detector, so it adds 3 cycles of latency. sw_trig is used directly.
- States: IDLE(0), FIFO_RST(1), SETTLE(2), ARMED(3), CAPTURE(4), DONE(5).
- IDLE or DONE, arm=1 -> FIFO_RST. On that edge: latch capture_len, clear sample_count, clear overflow, clear done.
- FIFO_RST: fifo_rstn=0 for exactly FIFO_RST_CYCLES cycles, then -> SETTLE.
- SETTLE: fifo_rstn=1, wait SETTLE_CYCLES cycles, then -> ARMED. Triggers arriving during FIFO_RST or SETTLE are discarded.
- ARMED: wait for a qualified trigger per trig_sel, then -> CAPTURE. If the latched length is 0, go directly -> DONE and never assert read_en.
- With trig_sel=3, ARMED lasts exactly one cycle.
- CAPTURE:
  - read_en=1 starting the cycle after the trigger is accepted.
  - sample_count increments every cycle read_en=1.
  - read_en drops the cycle after sample_count reaches the latched length, so exactly capture_len cycles have read_en=1. Then -> DONE.
- Overflow: if any fifo_full bit is 1 while read_en=1, set overflow, drop read_en next cycle, -> DONE. sample_count then holds the number of write-enabled cycles.
- DONE: done=1 and hold until arm (rearm) or abort.
- abort in any state -> IDLE next cycle: read_en=0, fifo_rstn=1, done=0. sample_count and overflow are held.
- Simultaneous events:
  - abort beats arm.
  - arm is ignored in FIFO_RST, SETTLE, ARMED and CAPTURE.
  - In ARMED, a trigger coinciding with arm is accepted; the arm is ignored.
- Counters saturate; none wrap. capture_len = 2^CNT_WIDTH-1 is legal.
- rst asserted mid-capture: read_en and all state clear immediately (asynchronous).

Decomposition:
- Package adc_ctrl_pkg holds:
  - state enum capture_state_e (3-bit encodings above);
  - trig_sel encodings TRIG_SW, TRIG_EXT, TRIG_ANY, TRIG_IMM.
- One sub-module, trig_sync_edge: 2-FF synchronizer plus rising-edge pulse for ext_trig, with async active-high reset.
- Counters and FSM live in the top module.

Test Plan:
- Normal sw capture: capture_len=100, trig_sel=0, arm, then sw_trig 10 cycles after ARMED.
  -> fifo_rstn low exactly 8 cycles; read_en high exactly 100 cycles; sample_count=100; done=1; overflow=0.
- External trigger: trig_sel=1, ext_trig rises asynchronously; also pulse sw_trig while ARMED.
  -> sw_trig ignored; read_en rises 4 cycles after the ext_trig edge is sampled; 100 samples written.
- Overflow: capture_len=50, fifo_full[2]=1 at the 20th write cycle.
  -> overflow=1; read_en low next cycle; sample_count=20; state DONE.
- Abort mid-capture: abort at the 30th write cycle of capture_len=100.
  -> read_en=0 next cycle; state IDLE; done=0; sample_count=30.
- Edge cases:
  - capture_len=0 with trig_sel=3 -> DONE without read_en ever asserting.
  - arm during CAPTURE -> ignored; capture completes at the original length.
  - Trigger during SETTLE -> discarded; no capture until a later trigger.
- Async reset: assert rst for 1 ns mid-CAPTURE, off-edge -> all outputs at reset values before the next clk edge.
